// File: rtl/muldiv_hilo.sv
// Multi-cycle unsigned multiply (shift-add) / divide (restoring) unit with HI/LO result registers.
// One iteration per clock over 32 cycles; dataOut muxes HI/LO onto the write-back bus.
module muldiv_hilo #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'd25,
    parameter logic [5:0]  DIVU  = 6'd27,
    parameter logic [5:0]  MFHI  = 6'd16,
    parameter logic [5:0]  MFLO  = 6'd18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       funct,
    input  logic             start,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [4:0]           r_count;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH+1:0]     w_rem_sh;
    logic                 w_fits;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    assign w_accept = (r_state == S_IDLE || r_state == S_DONE) && start;
    assign w_last   = (r_count == 5'd31);

    // Multiply step: conditional add into the upper half, then shift {carry, acc} right.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_acc_next = (2*WIDTH)'({w_sum, r_acc[WIDTH-1:0]} >> 1);

    // Divide step: shift {rem, quo} left, keep the difference only when it does not borrow.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_fits     = (w_rem_sh >= {2'b00, r_b});
    assign w_diff     = w_rem_sh[WIDTH:0] - {1'b0, r_b};
    assign w_rem_next = w_fits ? w_diff : w_rem_sh[WIDTH:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept && funct == MULTU) begin
                        r_a     <= dataA;
                        r_b     <= dataB;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MUL;
                    end else if (w_accept && funct == DIVU) begin
                        r_b     <= dataB;
                        r_rem   <= '0;
                        r_quo   <= dataA;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_DIV;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_acc   <= w_acc_next;
                    r_b     <= r_b >> 1;
                    r_count <= r_count + 5'd1;
                    if (w_last) begin
                        r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_lo    <= w_acc_next[WIDTH-1:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 5'd1;
                    if (w_last) begin
                        r_hi    <= w_rem_next[WIDTH-1:0];
                        r_lo    <= w_quo_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dataOut = '0;
        if (funct == MFHI) begin
            dataOut = r_hi;
        end else if (funct == MFLO) begin
            dataOut = r_lo;
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed corner cases plus randomized MULTU/DIVU
// against a plain-arithmetic model of HI/LO, latency, busy window and reset abort.
module tb_muldiv_hilo;

    localparam logic [5:0] MULTU = 6'd25;
    localparam logic [5:0] DIVU  = 6'd27;
    localparam logic [5:0] MFHI  = 6'd16;
    localparam logic [5:0] MFLO  = 6'd18;

    logic        clk;
    logic        rst;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  funct;
    logic        start;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;

    int          checks;
    int          failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_hilo #(
        .WIDTH (32),
        .MULTU (MULTU),
        .DIVU  (DIVU),
        .MFHI  (MFHI),
        .MFLO  (MFLO)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .dataA   (dataA),
        .dataB   (dataB),
        .funct   (funct),
        .start   (start),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] prod;
        if (f == MULTU) begin
            prod = 64'(a) * 64'(b);
            eh   = prod[63:32];
            el   = prod[31:0];
        end else if (b == 32'd0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
        end else begin
            eh = a % b;
            el = a / b;
        end
    endtask

    // Present a start request and let the next rising edge accept it; operands are scrambled after.
    task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        funct = f;
        dataA = a;
        dataB = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = MFLO;
        dataA = $urandom;
        dataB = $urandom;
    endtask

    // Waits for done after an accept edge; optionally pulses an ignored DIVU start at busy cycle 'inject'.
    task automatic wait_done(input int inject);
        int lat;
        int busy_cnt;
        lat      = 99;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (k == 0 || k == 16) check("busy_mflo_prev", dataOut, m_lo);
            if (busy) busy_cnt++;
            if (k == inject) begin
                start = 1'b1;
                funct = DIVU;
                dataA = 32'd9;
                dataB = 32'd3;
            end
            if (k == inject + 1) begin
                start = 1'b0;
                funct = MFLO;
            end
        end
        check("latency", lat, 32);
        check("busy_cycles", busy_cnt, 32);
        check("busy_at_done", busy, 1'b0);
    endtask

    task automatic check_result(input logic [31:0] eh, input logic [31:0] el);
        funct = MFHI;
        #1 check("hi", dataOut, eh);
        funct = MFLO;
        #1 check("lo", dataOut, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [31:0] eh;
        logic [31:0] el;
        model(f, a, b, eh, el);
        launch(f, a, b);
        wait_done(inject);
        check_result(eh, el);
        $display("op funct=%0d a=%08h b=%08h -> hi=%08h lo=%08h", f, a, b, eh, el);
    endtask

    // One cycle after a done pulse with no new start: pulse must be gone and unit idle.
    task automatic idle();
        @(negedge clk);
        check("done_once", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          done_seen;

        checks   = 0;
        failures = 0;
        m_hi     = '0;
        m_lo     = '0;
        rst      = 1'b0;
        start    = 1'b0;
        funct    = MFLO;
        dataA    = '0;
        dataB    = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        funct = MFHI;
        #1 check("rst_hi", dataOut, 32'd0);
        funct = MFLO;
        #1 check("rst_lo", dataOut, 32'd0);
        funct = 6'd0;
        #1 check("other_funct_zero", dataOut, 32'd0);
        funct = MFLO;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op(MULTU, 32'd7, 32'd6, -1);
        check("mul7x6_lo_const", m_lo, 32'h0000_002A);
        idle();
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        idle();
        run_op(DIVU, 32'd100, 32'd7, -1);
        idle();
        run_op(DIVU, 32'd5, 32'd0, -1);
        check("div0_lo_const", m_lo, 32'hFFFF_FFFF);
        idle();

        run_op(MULTU, 32'd3, 32'd4, 10);
        idle();

        // Back-to-back: new start in the done cycle goes straight back to busy.
        run_op(MULTU, 32'd2, 32'd2, -1);
        run_op(DIVU, 32'd8, 32'd2, -1);
        idle();

        // Start with a non-launch funct is ignored.
        funct = MFHI;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = MFLO;
        @(negedge clk);
        check("ignored_start_busy", busy, 1'b0);

        for (int i = 0; i < 24; i++) begin
            f = ($urandom_range(0, 1) == 0) ? MULTU : DIVU;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'd1;
                2: a = 32'hFFFF_FFFF;
                3: b = $urandom_range(1, 15);
                default: ;
            endcase
            run_op(f, a, b, -1);
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();

        // Reset mid-operation: abort, clear HI/LO, no done pulse.
        run_op(DIVU, 32'd47, 32'd7, -1);
        idle();
        launch(MULTU, 32'd123, 32'd456);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        funct = MFHI;
        #1 check("abort_hi", dataOut, 32'd0);
        funct = MFLO;
        #1 check("abort_lo", dataOut, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b1;
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_idle_busy", busy, 1'b0);
        $display("reset abort: done pulses=%0d", done_seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Multi-cycle unsigned multiply/divide unit with HI/LO registers, placed in the execute stage beside the 32-bit ALU. It takes the same `dataA`/`dataB` operand buses that feed the ALU. It runs MULTU/DIVU over 32 iterations and returns HI/LO through MFHI/MFLO onto a 32-bit result bus that the write-back mux selects in place of the ALU `dataOut`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.
- `MULTU`, default 6'd25: funct code for multiply.
- `DIVU`, default 6'd27: funct code for divide.
- `MFHI`, default 6'd16: funct code for read HI.
- `MFLO`, default 6'd18: funct code for read LO.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `dataA`, input, 32: multiplicand or dividend (rs).
- `dataB`, input, 32: multiplier or divisor (rt).
- `funct`, input, 6: operation select.
- `start`, input, 1: launch request. Sampled only with `funct` equal to MULTU or DIVU.
- `dataOut`, output, 32: HI when `funct`=MFHI, LO when `funct`=MFLO, otherwise 0. Combinational from the HI/LO registers.
- `busy`, output, 1: high while an operation is iterating.
- `done`, output, 1: one-cycle pulse in the cycle after HI/LO commit.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE or DONE, `start`=1, `funct`=MULTU: latch operands, clear the 64-bit accumulator, set count=0, go to MUL.
- IDLE or DONE, `start`=1, `funct`=DIVU: latch operands, clear the 33-bit remainder, load the quotient register with the dividend, set count=0, go to DIV.
- `start` with any other funct: ignored.
- MUL (shift-add, LSB-first):
  - Each cycle, if multiplier[0] is 1, add the multiplicand into acc[63:32] with a 33-bit sum.
  - Then shift {carry, acc} right by 1 and shift the multiplier right by 1.
  - After the 32nd iteration (count=31), commit HI=acc[63:32] and LO=acc[31:0], then go to DONE.
- DIV (restoring):
  - Each cycle, shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - If there is no borrow, keep the difference and set quo[0]=1. Otherwise restore rem and set quo[0]=0.
  - After the 32nd iteration, commit HI=rem[31:0] and LO=quo, then go to DONE.
- Divide by zero: no special path. The restoring algorithm naturally yields LO=32'hFFFFFFFF and HI=dividend; verify this exactly.
- DONE: lasts one cycle, then goes to IDLE unless a new `start` is accepted, which goes straight to MUL or DIV.
- `start` while in MUL or DIV is ignored. Operands and `funct` do not need to be held after the accept cycle.
- HI/LO change only at commit. During `busy`, MFHI/MFLO return the previous result.
- Count is 5 bits. The operation terminates at count==31; wrap-around is never used.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, count=0, HI=0, LO=0, acc/rem/quo=0, `busy`=0, `done`=0, `dataOut`=0 (for MFHI/MFLO).
- Reset asserted mid-operation aborts immediately. HI/LO read 0 afterwards and no `done` pulse is produced.
- Accept edge is edge 0. `busy`=1 after edge 0 through edge 32, i.e. exactly 32 cycles.
- HI/LO commit on edge 32. `done`=1 and `busy`=0 after edge 32, for one cycle.
- Total latency from the start edge to the `done` cycle is 32 cycles.
- Back-to-back: `start` in the DONE cycle is accepted, so `busy` rises again on the next edge with no IDLE cycle.
- `dataOut` is combinational from HI/LO and `funct`: valid in the same cycle as `funct` changes, and in the `done` cycle for the fresh result.
- `busy` and `done` are registered, decoded from state with no combinational path from inputs.

## Test plan
- MULTU 7 × 6, then MFLO and MFHI -> `done` 32 cycles after the accept edge; LO=32'h0000002A, HI=0.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
- DIVU 100 ÷ 7 -> LO=14, HI=2. DIVU 5 ÷ 0 -> LO=32'hFFFFFFFF, HI=5.
- MULTU 3 × 4; pulse `start` with DIVU 9 ÷ 3 at cycle 10 of the operation -> second start ignored; HI=0, LO=12; `done` pulses once.
- MULTU 2 × 2 completes; issue DIVU 8 ÷ 2 in the `done` cycle -> `busy` re-asserts on the next edge; during `busy`, MFLO returns 4; after completion LO=4, HI=0.
- With HI/LO holding 5/6, start MULTU, then drop `rst` at busy cycle 10 -> `busy`=0, `done` never pulses, MFHI and MFLO both read 0.
